// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: one outstanding imem
// request, one-entry skid buffer for decode stalls, discard of responses after redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_valid
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_DISCARD,
        S_HOLD
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] req_addr_q;
    logic [31:0] pend_q;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic [31:0] tgt;
    logic [31:0] discard_next;

    assign tgt          = {redirect_target[31:2], 2'b00};
    assign discard_next = redirect_valid ? tgt : pend_q;

    // Gated by reset directly so no request is visible while reset is held.
    assign imem_req  = !reset && (state != S_HOLD);
    assign imem_addr = req_addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            pend_q     <= '0;
            skid_instr <= NOP_INSTR;
            skid_pc    <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        if (redirect_valid) begin
                            pc_q       <= tgt;
                            req_addr_q <= tgt;
                        end else if (id_stall) begin
                            skid_instr <= imem_rdata;
                            skid_pc    <= req_addr_q;
                            pc_q       <= req_addr_q + 32'd4;
                            state      <= S_HOLD;
                        end else begin
                            pc_q       <= req_addr_q + 32'd4;
                            req_addr_q <= req_addr_q + 32'd4;
                        end
                    end else if (redirect_valid) begin
                        pend_q <= tgt;
                        state  <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (imem_ack) begin
                        pc_q       <= discard_next;
                        req_addr_q <= discard_next;
                        state      <= S_FETCH;
                    end else if (redirect_valid) begin
                        pend_q <= tgt;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        skid_instr <= NOP_INSTR;
                        skid_pc    <= '0;
                        pc_q       <= tgt;
                        req_addr_q <= tgt;
                        state      <= S_FETCH;
                    end else if (!id_stall) begin
                        req_addr_q <= pc_q;
                        state      <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    // IF/ID: redirect flush beats stall, stall beats load/bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_instr <= NOP_INSTR;
            id_pc    <= '0;
            id_valid <= 1'b0;
        end else if (redirect_valid) begin
            id_instr <= NOP_INSTR;
            id_valid <= 1'b0;
        end else if (!id_stall) begin
            if (state == S_FETCH && imem_ack) begin
                id_instr <= imem_rdata;
                id_pc    <= req_addr_q;
                id_valid <= 1'b1;
            end else if (state == S_HOLD) begin
                id_instr <= skid_instr;
                id_pc    <= skid_pc;
                id_valid <= 1'b1;
            end else begin
                id_instr <= NOP_INSTR;
                id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a program-order scoreboard of expected
// (pc, instr) pairs is consumed by a monitor whenever decode accepts an instruction.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_valid;

    fetch_stage #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .id_stall       (id_stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_valid       (id_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    int unsigned vectors = 0;
    int unsigned errors  = 0;
    exp_t        expq[$];
    logic [31:0] nxt_pc;
    bit          mon_en = 1'b0;
    bit          prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;
    int unsigned idle = 0;
    exp_t        mon_e;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h0000_A5A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_next();
        expq.push_back('{nxt_pc, mem_word(nxt_pc)});
        nxt_pc = nxt_pc + 32'd4;
    endtask

    // Program order restarts at the (word-aligned) target; anything older is dead.
    task automatic restart(input logic [31:0] target);
        expq.delete();
        nxt_pc = {target[31:2], 2'b00};
        repeat (4) push_next();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_pend) begin
                check("req_held", 32'(imem_req), 32'd1);
                check("addr_held", imem_addr, prev_addr);
            end
            prev_pend = imem_req && !imem_ack;
            prev_addr = imem_addr;
            if (!id_valid)
                check("bubble_nop", id_instr, NOP);
            if (id_valid && !id_stall && !redirect_valid) begin
                idle = 0;
                if (expq.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL scoreboard_empty: got pc %h expected no delivery", id_pc);
                end else begin
                    mon_e = expq.pop_front();
                    check("id_pc", id_pc, mon_e.pc);
                    check("id_instr", id_instr, mon_e.instr);
                    push_next();
                end
            end else begin
                idle++;
                if (idle > 200) begin
                    vectors++;
                    errors++;
                    $display("FAIL progress: got %0d idle cycles expected at most 200", idle);
                    idle = 0;
                end
            end
        end
    end

    initial begin
        logic [31:0] tgt;

        #1 reset = 1'b1;
        #2;
        check("rst_valid", 32'(id_valid), 32'd0);
        check("rst_instr", id_instr, NOP);
        check("rst_pc", id_pc, 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        restart(RST_PC);
        #9 reset = 1'b0;
        #1;
        mon_en = 1'b1;

        // Back-to-back acks: one address per cycle, IF/ID one cycle behind.
        for (int i = 0; i < 4; i++) begin
            check("seq_req", 32'(imem_req), 32'd1);
            check("seq_addr", imem_addr, RST_PC + 32'(4 * i));
            if (i > 0) begin
                check("seq_valid", 32'(id_valid), 32'd1);
                check("seq_id_pc", id_pc, RST_PC + 32'(4 * (i - 1)));
            end
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            @(posedge clk);
            #1;
        end

        for (int n = 0; n < 3000; n++) begin
            id_stall       = ($urandom_range(99) < 25);
            redirect_valid = ($urandom_range(99) < 6);
            if (redirect_valid) begin
                case ($urandom_range(3))
                    0:       tgt = $urandom;
                    1:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
                    2:       tgt = 32'h0000_0802;
                    default: tgt = 32'h0000_0400 + 32'($urandom_range(63) * 4);
                endcase
                redirect_target = tgt;
                restart(tgt);
            end else begin
                redirect_target = $urandom;
            end
            imem_ack   = imem_req && ($urandom_range(99) < 65);
            imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
            @(posedge clk);
            #1;
        end

        // Get a valid word into IF/ID, then stall until the skid holds the next one.
        redirect_valid = 1'b0;
        id_stall       = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (id_valid) break;
            imem_ack   = imem_req;
            imem_rdata = mem_word(imem_addr);
            @(posedge clk);
            #1;
        end
        id_stall = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (!imem_req) break;
            imem_ack   = imem_req;
            imem_rdata = mem_word(imem_addr);
            @(posedge clk);
            #1;
        end
        imem_ack = 1'b0;
        check("hold_req", 32'(imem_req), 32'd0);
        check("hold_valid", 32'(id_valid), 32'd1);

        mon_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_valid", 32'(id_valid), 32'd0);
        check("async_instr", id_instr, NOP);
        check("async_req", 32'(imem_req), 32'd0);
        check("async_pc", id_pc, 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        id_stall = 1'b0;
        #1;
        check("post_rst_req", 32'(imem_req), 32'd1);
        check("post_rst_addr", imem_addr, RST_PC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the RISC-V pipeline. It holds the PC and issues one instruction-memory request at a time. It delivers each fetched word with its PC to the decode stage, where the immediate generator and the control decoder consume it. It handles decode stalls with a one-entry skid buffer, and taken-branch redirects with a discard of any in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven on id_instr when id_valid=0.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high reset.
imem_req  out  1  fetch request; address held stable while high and not acked.
imem_addr  out  32  fetch address, word aligned.
imem_ack  in  1  response strobe; qualifies imem_rdata; may assert in the same cycle as imem_req.
imem_rdata  in  32  fetched instruction.
id_stall  in  1  decode stage cannot accept; IF/ID holds.
redirect_valid  in  1  taken branch or jump resolved downstream; flush and refetch.
redirect_target  in  32  new PC; bits [1:0] ignored (treated as 0).
id_instr  out  32  IF/ID instruction register.
id_pc  out  32  IF/ID PC register.
id_valid  out  1  IF/ID valid.

Behaviour:
- Reset (async, any state or cycle):
  - pc_q=RESET_PC, state=S_FETCH.
  - id_instr=NOP_INSTR, id_pc=0, id_valid=0.
  - skid buffer empty, discard flag cleared.
  - imem_req forced 0 while reset is high.
  - First request issues in the first cycle after reset deasserts.
- Registers: pc_q (next PC to fetch), req_addr_q (address of the outstanding request), pend_q (pending redirect target), skid_instr/skid_pc.
- Outputs: imem_req=1 in S_FETCH and S_DISCARD, 0 in S_HOLD. imem_addr=req_addr_q.
- S_FETCH:
  - On entry, req_addr_q=pc_q.
  - ack & redirect_valid: drop imem_rdata; pc_q<=target; stay.
  - ack & !id_stall: IF/ID<={rdata, req_addr_q, 1}; pc_q<=req_addr_q+4; stay; the next request issues the following cycle.
  - ack & id_stall: skid<={rdata, req_addr_q}; pc_q<=req_addr_q+4; go S_HOLD.
  - !ack & redirect_valid: pend_q<=target; go S_DISCARD. The address stays stable because the request is still outstanding.
  - !ack otherwise: stay; keep requesting.
- S_DISCARD:
  - Request stays high at the old address.
  - A redirect here overwrites pend_q (last target wins).
  - On ack: drop rdata; pc_q<=pend_q (or the same-cycle redirect_target); go S_FETCH.
- S_HOLD:
  - No request.
  - redirect_valid: clear skid; pc_q<=target; go S_FETCH.
  - Else if !id_stall: IF/ID<={skid, 1}; go S_FETCH.
- IF/ID register update, in priority order:
  1. redirect_valid: id_valid<=0, id_instr<=NOP_INSTR. Applies regardless of id_stall.
  2. id_stall: hold all three registers.
  3. Otherwise: load the fetched or skid word, else insert a bubble (id_valid<=0, NOP_INSTR).
- Arithmetic: PC increment is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0. Redirect targets are masked to {target[31:2],2'b00}.
- Ordering: exactly one request outstanding; responses are accepted only while imem_req=1. A response is never delivered to IF/ID after a redirect that occurred before or in its ack cycle. No instruction is lost or duplicated across stalls.
- Latency: ack in cycle N gives id_valid=1 in cycle N+1 (no stall). Back-to-back same-cycle acks give one instruction per cycle.

Test Plan:
- Sequential fetch: reset with RESET_PC=0x100, then imem_ack=1 every cycle with rdata=addr^0xA5A5 -> imem_addr 0x100,0x104,0x108 on consecutive cycles. id_pc follows one cycle later with id_valid=1 and id_instr matching.
- Stall/skid: assert id_stall for 3 cycles while the fetch of 0x108 acks -> IF/ID holds 0x104, imem_req=0 during the stall. On release, id_pc=0x108 the next cycle, then 0x10C; no gap, no duplicate.
- Redirect during outstanding request: request to 0x200 unacked, redirect_valid with target 0x400. Ack arrives 2 cycles later with 0xDEADBEEF -> word discarded, id_valid=0. Next imem_addr=0x400.
- Redirect with stall: id_stall=1 and redirect_valid in the same cycle, target 0x802 -> id_valid=0 next cycle, skid cleared, next imem_addr=0x800.
- Wrap: redirect to 0xFFFF_FFFC, ack -> id_pc=0xFFFF_FFFC, next imem_addr=0x0000_0000.
- Async reset mid-stall in S_HOLD -> outputs reset immediately without a clock edge: id_valid=0, id_instr=0x13, imem_req=0. After release, imem_addr=RESET_PC.
